bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the binary input; SHALL be >= 1.
REQ-002 Parameter DIGITS, default 3: number of BCD digits produced; SHALL be >= 1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: conversion request, sampled on the rising edge.
REQ-006 Port bin, input, WIDTH: unsigned binary value, captured only in the cycle start is accepted.
REQ-007 Port busy, output, 1: high while a conversion is in progress, including the done cycle.
REQ-008 Port done, output, 1: one-cycle pulse marking a new valid result.
REQ-009 Port bcd, output, 4*DIGITS: result; digit k in bits [4k+3:4k], with k=0 as the units digit; each digit feeds the seven-segment decoder directly.
REQ-010 Port ovf, output, 1: high when the last captured bin value exceeded 10^DIGITS-1.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start=1.
- SHIFT -> DONE after exactly WIDTH shift iterations.
- DONE -> IDLE unconditionally.
REQ-012 start SHALL be accepted only in IDLE and ignored in SHIFT and DONE, with no queuing and no effect on the running conversion.
REQ-013 On acceptance, bin SHALL be loaded into an internal shift register, the BCD work register SHALL be cleared, the iteration counter SHALL be cleared and the overflow accumulator SHALL be cleared.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble step in this order:
- add 3 to every work digit >= 5;
- shift {work, binary} left by 1.
REQ-015 A 1 shifted out of the top work digit in any SHIFT cycle SHALL set the overflow accumulator.
REQ-016 On the SHIFT->DONE transition, bcd SHALL be registered as follows:
- if the overflow accumulator is set, all digits SHALL be 4'h9 and ovf SHALL be 1;
- otherwise, the work register SHALL be copied to bcd and ovf SHALL be 0.
REQ-017 done SHALL be 1 only in the DONE state, so it is a one-cycle pulse.
REQ-018 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH, and bcd/ovf SHALL be valid from that same edge.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE, and combinational decode of the state SHALL be the only source of busy.
REQ-020 bcd and ovf SHALL hold their last values in all states other than the DONE transition; intermediate work values SHALL never appear on bcd.
REQ-021 Every bcd digit SHALL always be in the range 0..9.
REQ-022 bin changes after acceptance SHALL NOT affect the result.
REQ-023 If start is high continuously, back-to-back conversions SHALL start every WIDTH+2 cycles, with IDLE occupied for one cycle between them.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- busy, done and ovf to 0;
- bcd to all zeros;
- the counter and work registers to 0.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after rst deasserts SHALL begin a fresh conversion.

Verification
REQ-026 WIDTH=8, DIGITS=3, bin=255, start pulsed for 1 cycle -> done high in exactly the 9th cycle after the start edge, bcd=12'h255, ovf=0, busy high for 9 cycles.
REQ-027 bin=0 -> bcd=12'h000, ovf=0; then bin=99 -> bcd=12'h099; bcd unchanged between the two done pulses.
REQ-028 bin=128 accepted, then start=1 and bin=7 applied during SHIFT -> a single done pulse, bcd=12'h128, with no second conversion until the FSM returns to IDLE.
REQ-029 WIDTH=8, DIGITS=2, bin=100 -> ovf=1, bcd=8'h99; then bin=42 -> ovf=0, bcd=8'h42.
REQ-030 rst asserted 4 cycles into a conversion of bin=200 -> outputs zero asynchronously and no done pulse; after release, bin=37 -> bcd=12'h037 after the standard latency.
REQ-031 Exhaustive sweep of bin=0..255 with DIGITS=3 -> every result equals the decimal value of bin, and every digit is <= 9.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter that saturates to all-nines on overflow
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] work, adj, work_nx;
  logic [CW-1:0] cnt;
  logic acc, shout, ovf_nx, last, accept;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g+:4] = work[4*g+:4] >= 4'd5 ? work[4*g+:4] + 4'd3 : work[4*g+:4];
  end
  assign {shout, work_nx} = {adj, sr[WIDTH-1]};
  assign ovf_nx = acc | shout;
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, leave SHIFT after the last iteration, DONE lasts one cycle
  always_comb
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  // datapath: capture on accept, one adjust-then-shift step per SHIFT cycle, register result on the final step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr   <= '0;
      work <= '0;
      cnt  <= '0;
      acc  <= 1'b0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else if (accept) begin
      sr   <= bin;
      work <= '0;
      cnt  <= '0;
      acc  <= 1'b0;
    end else if (state == SHIFT) begin
      sr   <= sr << 1;
      work <= work_nx;
      cnt  <= cnt + 1'b1;
      acc  <= ovf_nx;
      if (last) begin
        bcd <= ovf_nx ? {DIGITS{4'h9}} : work_nx;
        ovf <= ovf_nx;
      end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vector bench for bin_to_bcd_seq at DIGITS=3 and DIGITS=2
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start3 = 1'b0, start2 = 1'b0;
  logic [7:0] bin3 = '0, bin2 = '0;
  logic busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0] bcd2;
  logic [11:0] last3 = '0;
  int pass = 0, total = 0;

  typedef struct { logic [7:0] b; logic [11:0] e; } v3_t;
  typedef struct { logic [7:0] b; logic [7:0] e; logic o; } v2_t;
  v3_t t3[8];
  v2_t t2[5];

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
  );
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else pass++;
  endtask

  task automatic run3(input logic [7:0] v, input logic [11:0] eb, input string nm);
    int n;
    @(negedge clk);
    bin3 = v;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    bin3 = ~v;
    n = 1;
    while (!done3 && n < 20) begin
      chk({nm, " busy"}, busy3, 1);
      chk({nm, " hold"}, bcd3, last3);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 9);
    chk({nm, " bcd"}, bcd3, eb);
    chk({nm, " ovf"}, ovf3, 0);
    chk({nm, " busy@done"}, busy3, 1);
    @(negedge clk);
    chk({nm, " done pulse"}, done3, 0);
    chk({nm, " idle"}, busy3, 0);
    last3 = eb;
  endtask

  task automatic run2(input logic [7:0] v, input logic [7:0] eb, input logic eo, input string nm);
    int n;
    @(negedge clk);
    bin2 = v;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 9);
    chk({nm, " bcd"}, bcd2, eb);
    chk({nm, " ovf"}, ovf2, eo);
    @(negedge clk);
  endtask

  initial begin
    t3[0] = '{8'd255, 12'h255};
    t3[1] = '{8'd0,   12'h000};
    t3[2] = '{8'd99,  12'h099};
    t3[3] = '{8'd1,   12'h001};
    t3[4] = '{8'd9,   12'h009};
    t3[5] = '{8'd10,  12'h010};
    t3[6] = '{8'd100, 12'h100};
    t3[7] = '{8'd199, 12'h199};
    t2[0] = '{8'd100, 8'h99, 1'b1};
    t2[1] = '{8'd42,  8'h42, 1'b0};
    t2[2] = '{8'd99,  8'h99, 1'b0};
    t2[3] = '{8'd255, 8'h99, 1'b1};
    t2[4] = '{8'd5,   8'h05, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk("reset busy", busy3, 0);
    chk("reset done", done3, 0);
    chk("reset bcd", bcd3, 0);
    chk("reset ovf", ovf3, 0);
    chk("reset bcd2", bcd2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run3(t3[i].b, t3[i].e, $sformatf("vec3[%0d]", i));

    @(negedge clk);
    bin3 = 8'd128;
    start3 = 1'b1;
    @(negedge clk);
    bin3 = 8'd7;
    for (int i = 1; i <= 19; i++) begin
      chk($sformatf("b2b done c%0d", i), done3, (i == 9 || i == 19) ? 1 : 0);
      if (i == 5) chk("b2b hold", bcd3, last3);
      if (i == 9) chk("b2b first bcd", bcd3, 12'h128);
      if (i == 10) chk("b2b idle gap", busy3, 0);
      if (i == 11) start3 = 1'b0;
      if (i == 19) chk("b2b second bcd", bcd3, 12'h007);
      @(negedge clk);
    end
    last3 = 12'h007;

    for (int i = 0; i < 5; i++) run2(t2[i].b, t2[i].e, t2[i].o, $sformatf("vec2[%0d]", i));

    @(negedge clk);
    bin3 = 8'd200;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", busy3, 0);
    chk("abort done", done3, 0);
    chk("abort bcd", bcd3, 0);
    chk("abort ovf", ovf3, 0);
    chk("abort bcd2", bcd2, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort in reset", done3, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort no done", done3, 0);
      chk("abort no busy", busy3, 0);
    end
    last3 = '0;
    run3(8'd37, 12'h037, "after reset");

    for (int v = 0; v < 256; v++) begin
      run3(8'(v), {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}, $sformatf("sweep %0d", v));
      chk("sweep digits", (bcd3[3:0] <= 4'd9) && (bcd3[7:4] <= 4'd9) && (bcd3[11:8] <= 4'd9), 1);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
